// File: rtl/async_fifo_pkg.sv
// Shared types and widths for the async FIFO read-port drainer.
package async_fifo_pkg;

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/async_fifo_rdport_if.sv
// Read-side FIFO pop bus plus the downstream valid/ready stream.
// master = the read-port block (pops the FIFO, drives the stream);
// slave  = its surroundings (the FIFO and the stream consumer).
interface async_fifo_rdport_if #(
    parameter int unsigned DSIZE = 32
);
    logic             rempty;
    logic [DSIZE-1:0] rdata;
    logic             rinc;
    logic             m_valid;
    logic             m_ready;
    logic [DSIZE-1:0] m_data;
    logic             m_burst_end;

    modport master (
        input  rempty,
        input  rdata,
        output rinc,
        output m_valid,
        input  m_ready,
        output m_data,
        output m_burst_end
    );

    modport slave (
        output rempty,
        output rdata,
        input  rinc,
        input  m_valid,
        output m_ready,
        input  m_data,
        input  m_burst_end
    );
endinterface

// File: rtl/rd_skid_buffer.sv
// Two-entry in-order output buffer; head entry drives the stream outputs.
module rd_skid_buffer #(
    parameter int unsigned WIDTH = 33
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full
);
    logic [1:0]       r_occ;
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic             w_pop;
    logic             w_push;

    assign w_pop   = (r_occ != 2'd0) && i_ready;
    assign w_push  = i_push && (r_occ != 2'd2);
    assign o_valid = (r_occ != 2'd0);
    assign o_full  = (r_occ == 2'd2);
    assign o_dout  = r_head;

    // Occupancy and entry update; a push and pop at occ=1 refill the head in place.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_occ  <= 2'd0;
            r_head <= '0;
            r_tail <= '0;
        end else begin
            case (r_occ)
                2'd0: begin
                    if (w_push) begin
                        r_head <= i_din;
                        r_occ  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (w_push && w_pop) begin
                        r_head <= i_din;
                    end else if (w_push) begin
                        r_tail <= i_din;
                        r_occ  <= 2'd2;
                    end else if (w_pop) begin
                        r_occ  <= 2'd0;
                    end
                end
                default: begin
                    if (w_pop) begin
                        r_head <= r_tail;
                        r_occ  <= 2'd1;
                    end
                end
            endcase
        end
    end
endmodule

// File: rtl/async_fifo_rdport.sv
// Coalescing read port: waits for TIMEOUT idle cycles (or flush), then pops
// the async FIFO in bursts of up to MAXBURST words into a 2-entry buffer.
module async_fifo_rdport
    import async_fifo_pkg::*;
#(
    parameter int unsigned DSIZE    = 32,
    parameter int unsigned TIMEOUT  = 8,
    parameter int unsigned MAXBURST = 16
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic                flush,
    output logic [CNT_W-1:0]    pop_count,
    async_fifo_rdport_if.master bus
);
    localparam int unsigned TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned BUF_W = DSIZE + 1;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [TMR_W-1:0] r_timer;
    logic [CNT_W-1:0] r_burst_cnt;
    logic [CNT_W-1:0] r_pop_count;
    logic             r_armed;
    logic             w_enter_drain;
    logic             w_rinc;
    logic             w_last_pop;
    logic             w_full;
    logic             w_valid;
    logic [BUF_W-1:0] w_head;

    // Pop only from registered state/occupancy and rempty, never from m_ready.
    assign w_rinc     = (r_state == ST_DRAIN) && !bus.rempty && !w_full;
    assign w_last_pop = w_rinc && (r_burst_cnt == CNT_W'(MAXBURST - 1));

    assign bus.rinc        = w_rinc;
    assign bus.m_valid     = w_valid;
    assign bus.m_data      = w_head[DSIZE-1:0];
    assign bus.m_burst_end = w_head[DSIZE];
    assign pop_count       = r_pop_count;

    // State register; r_armed holds the FSM in IDLE for the first edge after reset.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_state <= ST_IDLE;
            r_armed <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_armed <= 1'b1;
        end
    end

    // Next-state logic: coalesce in WAIT, drain until burst limit or FIFO empty.
    always_comb begin
        w_state_nxt   = r_state;
        w_enter_drain = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_armed && !bus.rempty) begin
                    if (flush || (TIMEOUT == 0)) begin
                        w_state_nxt   = ST_DRAIN;
                        w_enter_drain = 1'b1;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (bus.rempty) begin
                    w_state_nxt = ST_IDLE;
                end else if (flush || (r_timer == TMR_W'(TIMEOUT - 1))) begin
                    w_state_nxt   = ST_DRAIN;
                    w_enter_drain = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (w_last_pop || (bus.rempty && !w_rinc)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Idle-coalescing timer: counts WAIT cycles, zero elsewhere.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_timer <= '0;
        end else if (r_state == ST_WAIT) begin
            r_timer <= r_timer + TMR_W'(1);
        end else begin
            r_timer <= '0;
        end
    end

    // Burst length counter, restarted on every entry into DRAIN.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_burst_cnt <= '0;
        end else if (w_enter_drain) begin
            r_burst_cnt <= '0;
        end else if (w_rinc) begin
            r_burst_cnt <= r_burst_cnt + CNT_W'(1);
        end
    end

    // Free-running pop counter, wraps at 2^16.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_pop_count <= '0;
        end else if (w_rinc) begin
            r_pop_count <= r_pop_count + CNT_W'(1);
        end
    end

    rd_skid_buffer #(
        .WIDTH (BUF_W)
    ) u_skid (
        .i_clk   (rclk),
        .i_rst_n (rrst_n),
        .i_push  (w_rinc),
        .i_din   ({w_last_pop, bus.rdata}),
        .i_ready (bus.m_ready),
        .o_valid (w_valid),
        .o_dout  (w_head),
        .o_full  (w_full)
    );
endmodule
